ex_stage: RTL

Execute stage of the 5-stage MIPS pipeline, directly upstream of the memory-access stage. It consumes the decoded instruction and register operands and computes the ALU result or load/store address. Its outputs are registered into the EX/MA pipeline register: Result, Rdata2, nextPC and Ins. It also owns the HI/LO registers and an iterative multiply/divide unit, and stalls the front end on HI/LO hazards.

---
 rtl/ex_stage_pkg.sv | 73 +++++++
 rtl/ex_stage_muldiv_unit.sv | 147 ++++++++++++++
 rtl/ex_stage.sv | 135 +++++++++++++
 3 files changed

// File: rtl/ex_stage_pkg.sv
// Shared opcode/funct encodings, multiply/divide FSM states and helpers for the MIPS execute stage.
package ex_stage_pkg;

    localparam int          MD_ITER     = 32;
    localparam int          CNT_W       = $clog2(MD_ITER);
    localparam logic [31:0] ZERO_DIV_LO = 32'hFFFF_FFFF;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_SLLV  = 6'h04;
    localparam logic [5:0] F_SRLV  = 6'h06;
    localparam logic [5:0] F_SRAV  = 6'h07;
    localparam logic [5:0] F_JR    = 6'h08;
    localparam logic [5:0] F_JALR  = 6'h09;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_t;

    // Order matches funct[1:0] of MULT/MULTU/DIV/DIVU.
    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    function automatic logic is_hilo_funct(input logic [5:0] f);
        return (f == F_MFHI) || (f == F_MFLO) || (f == F_MTHI) || (f == F_MTLO) ||
               (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
    endfunction

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/ex_stage_muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO: one result bit per cycle, MD_ITER cycles per op.
// With MULDIV_FAST_MUL_EN defined, MULT/MULTU complete combinationally at the start edge.
module muldiv_unit
    import ex_stage_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [1:0]  i_op,
    input  logic [31:0] i_rs,
    input  logic [31:0] i_rt,
    input  logic        i_mthi,
    input  logic        i_mtlo,
    output logic        o_busy,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    md_state_t          r_state;
    md_state_t          w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [63:0]        r_p;
    logic [31:0]        r_opnd;
    logic               r_is_div;
    logic               r_neg_lo;
    logic               r_neg_hi;
    logic               r_div_zero;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic               w_iter_op;
    logic               w_start_iter;
    logic               w_last;
    logic               w_signed;
    logic [31:0]        w_rs_mag;
    logic [31:0]        w_rt_mag;
    logic [32:0]        w_mul_sum;
    logic [63:0]        w_mul_step;
    logic [32:0]        w_div_sh;
    logic [32:0]        w_div_diff;
    logic [63:0]        w_div_step;
    logic [63:0]        w_p_nxt;
    logic [63:0]        w_prod;
    logic [31:0]        w_quo;
    logic [31:0]        w_rem;

`ifdef MULDIV_FAST_MUL_EN
    logic               w_fast_mul;
    logic [63:0]        w_fast_prod;
    assign w_iter_op   = i_op[1];
    assign w_fast_mul  = i_start & ~i_op[1] & (r_state == MD_IDLE);
    assign w_fast_prod = (md_op_t'(i_op) == MD_MULT)
                       ? 64'($signed({{32{i_rs[31]}}, i_rs}) * $signed({{32{i_rt[31]}}, i_rt}))
                       : ({32'h0, i_rs} * {32'h0, i_rt});
`else
    assign w_iter_op   = 1'b1;
`endif

    assign w_start_iter = i_start & w_iter_op & (r_state == MD_IDLE);
    assign w_last       = (r_state == MD_RUN) && (r_cnt == '0);
    assign w_signed     = (md_op_t'(i_op) == MD_MULT) || (md_op_t'(i_op) == MD_DIV);
    assign w_rs_mag     = mag32(i_rs, w_signed);
    assign w_rt_mag     = mag32(i_rt, w_signed);

    // Multiply: {acc, multiplier} shifts right, adding the multiplicand when the LSB is set.
    assign w_mul_sum  = {1'b0, r_p[63:32]} + (r_p[0] ? {1'b0, r_opnd} : 33'd0);
    assign w_mul_step = {w_mul_sum, r_p[31:1]};

    // Divide: {rem, quotient} shifts left; a non-negative trial difference sets the quotient bit.
    assign w_div_sh   = r_p[63:31];
    assign w_div_diff = w_div_sh - {1'b0, r_opnd};
    assign w_div_step = w_div_diff[32] ? {w_div_sh[31:0], r_p[30:0], 1'b0}
                                       : {w_div_diff[31:0], r_p[30:0], 1'b1};

    assign w_p_nxt = r_is_div ? w_div_step : w_mul_step;
    assign w_prod  = r_neg_lo ? (64'd0 - w_p_nxt) : w_p_nxt;
    assign w_quo   = r_div_zero ? ZERO_DIV_LO : (r_neg_lo ? (32'd0 - w_p_nxt[31:0]) : w_p_nxt[31:0]);
    assign w_rem   = r_neg_hi ? (32'd0 - w_p_nxt[63:32]) : w_p_nxt[63:32];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= MD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MD_IDLE: if (w_start_iter) w_state_nxt = MD_RUN;
            MD_RUN:  if (r_cnt == '0)  w_state_nxt = MD_IDLE;
            default: w_state_nxt = MD_IDLE;
        endcase
    end

    always_comb begin
        o_busy = (r_state == MD_RUN);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt      <= '0;
            r_p        <= '0;
            r_opnd     <= '0;
            r_is_div   <= 1'b0;
            r_neg_lo   <= 1'b0;
            r_neg_hi   <= 1'b0;
            r_div_zero <= 1'b0;
        end else if (w_start_iter) begin
            r_cnt      <= CNT_W'(MD_ITER - 1);
            r_is_div   <= i_op[1];
            r_p        <= {32'h0, (i_op[1] ? w_rs_mag : w_rt_mag)};
            r_opnd     <= i_op[1] ? w_rt_mag : w_rs_mag;
            r_neg_lo   <= w_signed & (i_rs[31] ^ i_rt[31]);
            r_neg_hi   <= w_signed & i_rs[31];
            r_div_zero <= i_op[1] & (i_rt == 32'h0);
        end else if (r_state == MD_RUN) begin
            r_p <= w_p_nxt;
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_last) begin
            r_hi <= r_is_div ? w_rem : w_prod[63:32];
            r_lo <= r_is_div ? w_quo : w_prod[31:0];
`ifdef MULDIV_FAST_MUL_EN
        end else if (w_fast_mul) begin
            r_hi <= w_fast_prod[63:32];
            r_lo <= w_fast_prod[31:0];
`endif
        end else begin
            if (i_mthi) r_hi <= i_rs;
            if (i_mtlo) r_lo <= i_rs;
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU/address calc into the EX/MA register (1-cycle latency), HI/LO via muldiv_unit.
// Stall holds decode only for HI/LO-touching ops while a multiply/divide runs; MULDIV_FAST_MUL_EN makes multiplies single-cycle.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        In_valid,
    input  logic [31:0] Ins,
    input  logic [31:0] Rdata1,
    input  logic [31:0] Rdata2,
    input  logic [31:0] Ed32,
    input  logic [31:0] nextPC,
    output logic        Stall,
    output logic        Out_valid,
    output logic [31:0] Result_o,
    output logic [31:0] Rdata2_o,
    output logic [31:0] nextPC_o,
    output logic [31:0] Ins_o,
    output logic        Md_busy
);

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_shamt;
    logic [4:0]  w_vshamt;
    logic [31:0] w_zimm;
    logic        w_rtype;
    logic        w_accept;
    logic        w_md_start;
    logic        w_mthi;
    logic        w_mtlo;
    logic        w_md_busy;
    logic [31:0] w_hi;
    logic [31:0] w_lo;
    logic [31:0] w_result;

    logic        r_out_valid;
    logic [31:0] r_result;
    logic [31:0] r_rdata2;
    logic [31:0] r_next_pc;
    logic [31:0] r_ins;

    assign w_op     = Ins[31:26];
    assign w_funct  = Ins[5:0];
    assign w_shamt  = Ins[10:6];
    assign w_vshamt = Rdata1[4:0];
    assign w_zimm   = {16'h0, Ins[15:0]};
    assign w_rtype  = (w_op == OP_RTYPE);

    // Busy comes straight from a flop, so Stall has no path through the HI/LO datapath.
    assign Stall    = In_valid & w_md_busy & w_rtype & is_hilo_funct(w_funct);
    assign w_accept = In_valid & ~Stall;

    assign w_md_start = w_accept & w_rtype & (w_funct[5:2] == F_MULT[5:2]);
    assign w_mthi     = w_accept & w_rtype & (w_funct == F_MTHI);
    assign w_mtlo     = w_accept & w_rtype & (w_funct == F_MTLO);

    muldiv_unit u_muldiv (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_start (w_md_start),
        .i_op    (w_funct[1:0]),
        .i_rs    (Rdata1),
        .i_rt    (Rdata2),
        .i_mthi  (w_mthi),
        .i_mtlo  (w_mtlo),
        .o_busy  (w_md_busy),
        .o_hi    (w_hi),
        .o_lo    (w_lo)
    );

    always_comb begin
        w_result = '0;
        if (w_rtype) begin
            case (w_funct)
                F_ADD, F_ADDU: w_result = Rdata1 + Rdata2;
                F_SUB, F_SUBU: w_result = Rdata1 - Rdata2;
                F_AND:         w_result = Rdata1 & Rdata2;
                F_OR:          w_result = Rdata1 | Rdata2;
                F_XOR:         w_result = Rdata1 ^ Rdata2;
                F_NOR:         w_result = ~(Rdata1 | Rdata2);
                F_SLT:         w_result = {31'h0, $signed(Rdata1) < $signed(Rdata2)};
                F_SLTU:        w_result = {31'h0, Rdata1 < Rdata2};
                F_SLL:         w_result = Rdata2 << w_shamt;
                F_SRL:         w_result = Rdata2 >> w_shamt;
                F_SRA:         w_result = $signed(Rdata2) >>> w_shamt;
                F_SLLV:        w_result = Rdata2 << w_vshamt;
                F_SRLV:        w_result = Rdata2 >> w_vshamt;
                F_SRAV:        w_result = $signed(Rdata2) >>> w_vshamt;
                F_MFHI:        w_result = w_hi;
                F_MFLO:        w_result = w_lo;
                default:       w_result = '0;
            endcase
        end else begin
            case (w_op)
                OP_ADDI, OP_ADDIU: w_result = Rdata1 + Ed32;
                OP_SLTI:           w_result = {31'h0, $signed(Rdata1) < $signed(Ed32)};
                OP_SLTIU:          w_result = {31'h0, Rdata1 < Ed32};
                OP_ANDI:           w_result = Rdata1 & w_zimm;
                OP_ORI:            w_result = Rdata1 | w_zimm;
                OP_XORI:           w_result = Rdata1 ^ w_zimm;
                OP_LUI:            w_result = {Ins[15:0], 16'h0};
                OP_LW, OP_SW:      w_result = Rdata1 + Ed32;
                default:           w_result = '0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_rdata2    <= '0;
            r_next_pc   <= '0;
            r_ins       <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_result    <= w_result;
            r_rdata2    <= Rdata2;
            r_next_pc   <= nextPC;
            r_ins       <= Ins;
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign Out_valid = r_out_valid;
    assign Result_o  = r_result;
    assign Rdata2_o  = r_rdata2;
    assign nextPC_o  = r_next_pc;
    assign Ins_o     = r_ins;
    assign Md_busy   = w_md_busy;

endmodule
